// File: rtl/servo_pwm_capture_pkg.sv
// Shared definitions for the servo PWM capture block.
// Holds the default timing constants (also used by the servo PWM generator)
// and the capture FSM state type.
package servo_pwm_capture_pkg;

   localparam int unsigned DEF_CLK_DIV    = 100;    // fabric cycles per 1 us tick
   localparam int unsigned DEF_CNT_W      = 16;     // width of us counters/results
   localparam int unsigned DEF_TIMEOUT_US = 50000;  // us without closing edge -> lost
   localparam int unsigned DEF_MIN_US     = 500;    // smallest legal pulse (inclusive)
   localparam int unsigned DEF_MAX_US     = 2500;   // largest legal pulse (inclusive)

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } cap_state_e;

endpackage

// File: rtl/servo_pwm_capture_sync.sv
// 2-FF synchronizer for the asynchronous PWM pin plus a 1-cycle edge detector.
// Ports:
//   clk     in  fabric clock
//   rst_n   in  asynchronous active-low reset
//   pwm_in  in  raw asynchronous PWM pin
//   rise_c  out combinational 1-cycle strobe on a synchronized rising edge
//   fall_c  out combinational 1-cycle strobe on a synchronized falling edge
module pwm_in_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic pwm_in,
   output logic rise_c,
   output logic fall_c
);

   // sh[0] metastable stage, sh[1] synchronized level, sh[2] previous level
   logic [2:0] sh;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh <= 3'b000;
      end else begin
         sh <= {sh[1:0], pwm_in};
      end
   end

   // Both edges take the same path, so measured widths are not skewed
   assign rise_c =  sh[1] & ~sh[2];
   assign fall_c = ~sh[1] &  sh[2];

endmodule

// File: rtl/servo_pwm_capture.sv
// Servo/RC PWM capture: measures high-pulse width and rising-to-rising period
// in whole microseconds using an internally derived 1 us timebase.
// Ports:
//   clk_100m    in   fabric clock (sole clock)
//   rst_n       in   asynchronous active-low reset
//   pwm_in      in   asynchronous PWM input from pin
//   pulse_us    out  last measured high width, us
//   period_us   out  last measured period, us
//   meas_valid  out  1-cycle strobe: pulse_us/period_us updated
//   range_err   out  pulse_us outside [MIN_US, MAX_US], updated with meas_valid
//   signal_lost out  no valid measurement since reset or timeout
module servo_pwm_capture
   import servo_pwm_capture_pkg::*;
#(
   parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
   parameter int unsigned CNT_W      = DEF_CNT_W,
   parameter int unsigned TIMEOUT_US = DEF_TIMEOUT_US,
   parameter int unsigned MIN_US     = DEF_MIN_US,
   parameter int unsigned MAX_US     = DEF_MAX_US
) (
   input  logic             clk_100m,
   input  logic             rst_n,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] pulse_us,
   output logic [CNT_W-1:0] period_us,
   output logic             meas_valid,
   output logic             range_err,
   output logic             signal_lost
);

   localparam int unsigned PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   logic             rise_c;
   logic             fall_c;
   logic             tick_c;
   logic [PRE_W-1:0] presc;
   logic [CNT_W-1:0] hi_cnt;
   logic [CNT_W-1:0] per_cnt;
   logic [CNT_W-1:0] hold;
   logic [CNT_W-1:0] hi_next_c;
   logic [CNT_W-1:0] per_next_c;
   logic             timeout_c;
   cap_state_e       state;

   pwm_in_sync u_sync (
      .clk    (clk_100m),
      .rst_n  (rst_n),
      .pwm_in (pwm_in),
      .rise_c (rise_c),
      .fall_c (fall_c)
   );

   // Counts including this cycle's tick, so a result is floor(cycles/CLK_DIV)
   assign tick_c     = (presc == PRE_W'(CLK_DIV - 1));
   assign hi_next_c  = hi_cnt + CNT_W'(tick_c);
   assign per_next_c = per_cnt + CNT_W'(tick_c);
   // >= keeps the counter bounded even if an edge deferred the exact match
   assign timeout_c  = (per_next_c >= CNT_W'(TIMEOUT_US));

   // Prescaler, restarted on every rising edge so the period aligns to it
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (rise_c || tick_c) begin
         presc <= '0;
      end else begin
         presc <= presc + PRE_W'(1);
      end
   end

   // Measurement FSM with registered outputs; edges take priority over timeout
   always_ff @(posedge clk_100m or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         hi_cnt      <= '0;
         per_cnt     <= '0;
         hold        <= '0;
         pulse_us    <= '0;
         period_us   <= '0;
         meas_valid  <= 1'b0;
         range_err   <= 1'b0;
         signal_lost <= 1'b1;
      end else begin
         meas_valid <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (rise_c) begin
                  state   <= ST_HIGH;
                  hi_cnt  <= '0;
                  per_cnt <= '0;
               end
            end
            ST_HIGH: begin
               if (fall_c) begin
                  state   <= ST_LOW;
                  hold    <= hi_next_c;
                  per_cnt <= per_next_c;
               end else if (timeout_c) begin
                  state       <= ST_IDLE;
                  signal_lost <= 1'b1;
               end else begin
                  hi_cnt  <= hi_next_c;
                  per_cnt <= per_next_c;
               end
            end
            ST_LOW: begin
               if (rise_c) begin
                  state       <= ST_HIGH;
                  pulse_us    <= hold;
                  period_us   <= per_next_c;
                  meas_valid  <= 1'b1;
                  range_err   <= (hold < CNT_W'(MIN_US)) || (hold > CNT_W'(MAX_US));
                  signal_lost <= 1'b0;
                  hi_cnt      <= '0;
                  per_cnt     <= '0;
               end else if (timeout_c) begin
                  state       <= ST_IDLE;
                  signal_lost <= 1'b1;
               end else begin
                  per_cnt <= per_next_c;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_servo_pwm_capture.sv
// Self-checking bench for servo_pwm_capture, run with a scaled timebase so the
// timeout and 50 Hz-style periods fit in a short simulation.
module tb_servo_pwm_capture;

   localparam int unsigned CLK_DIV    = 3;
   localparam int unsigned CNT_W      = 16;
   localparam int unsigned TIMEOUT_US = 2500;
   localparam int unsigned MIN_US     = 50;
   localparam int unsigned MAX_US     = 250;
   localparam int unsigned T_CYC      = TIMEOUT_US * CLK_DIV;

   typedef struct packed {
      logic [CNT_W-1:0] pulse;
      logic [CNT_W-1:0] period;
      logic             rerr;
      logic             lost;
   } meas_t;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             pwm_in = 1'b0;
   logic [CNT_W-1:0] pulse_us;
   logic [CNT_W-1:0] period_us;
   logic             meas_valid;
   logic             range_err;
   logic             signal_lost;

   int unsigned errors = 0;
   int unsigned checks = 0;
   int unsigned cyc = 0;

   meas_t obs_q[$];
   meas_t exp_q[$];

   // Reference model state: the pulse whose period is still open
   bit          pend_valid = 1'b0;
   int unsigned pend_hi = 0;
   int unsigned pend_per = 0;

   servo_pwm_capture #(
      .CLK_DIV    (CLK_DIV),
      .CNT_W      (CNT_W),
      .TIMEOUT_US (TIMEOUT_US),
      .MIN_US     (MIN_US),
      .MAX_US     (MAX_US)
   ) dut (
      .clk_100m    (clk),
      .rst_n       (rst_n),
      .pwm_in      (pwm_in),
      .pulse_us    (pulse_us),
      .period_us   (period_us),
      .meas_valid  (meas_valid),
      .range_err   (range_err),
      .signal_lost (signal_lost)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Collect every strobe with the qualifying outputs seen alongside it
   always @(negedge clk) begin
      if (rst_n && meas_valid === 1'b1) begin
         meas_t m;
         m.pulse  = pulse_us;
         m.period = period_us;
         m.rerr   = range_err;
         m.lost   = signal_lost;
         obs_q.push_back(m);
      end
   end

   // Expected report for a pulse of hi cycles inside a period of per cycles
   function automatic meas_t model_meas(input int unsigned hi, input int unsigned per);
      meas_t m;
      int unsigned p_us;
      p_us     = hi / CLK_DIV;
      m.pulse  = CNT_W'(p_us);
      m.period = CNT_W'(per / CLK_DIV);
      m.rerr   = (p_us < MIN_US) || (p_us > MAX_US);
      m.lost   = 1'b0;
      return m;
   endfunction

   task automatic model_rise();
      if (pend_valid) exp_q.push_back(model_meas(pend_hi, pend_per));
   endtask

   task automatic apply_reset();
      pwm_in = 1'b0;
      rst_n  = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      obs_q.delete();
      exp_q.delete();
      pend_valid = 1'b0;
   endtask

   // One full PWM cycle: high for hi cycles, next rise after per cycles
   task automatic drive_pulse(input int unsigned hi, input int unsigned per);
      @(negedge clk);
      model_rise();
      pend_valid = 1'b1;
      pend_hi    = hi;
      pend_per   = per;
      pwm_in     = 1'b1;
      repeat (hi) @(negedge clk);
      pwm_in = 1'b0;
      repeat (per - hi - 1) @(negedge clk);
   endtask

   // Closing rise that reports the last open period
   task automatic final_rise();
      @(negedge clk);
      model_rise();
      pend_valid = 1'b0;
      pwm_in     = 1'b1;
      repeat (6) @(negedge clk);
   endtask

   task automatic test_reset();
      rst_n  = 1'b0;
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (pulse_us !== '0 || period_us !== '0) begin
         errors++;
         $display("FAIL reset_results: pulse=%0d period=%0d, expected 0 0", pulse_us, period_us);
      end
      checks++;
      if (meas_valid !== 1'b0 || range_err !== 1'b0 || signal_lost !== 1'b1) begin
         errors++;
         $display("FAIL reset_flags: valid=%b rerr=%b lost=%b, expected 0 0 1",
                  meas_valid, range_err, signal_lost);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_nominal();
      apply_reset();
      drive_pulse(450, 3000);
      drive_pulse(450, 3000);
      final_rise();
      checks++;
      if (obs_q.size() != 2 || exp_q.size() != 2) begin
         errors++;
         $display("FAIL nominal_count: got %0d strobes, expected 2 (model %0d)", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL nominal_strobe%0d: got p=%0d per=%0d rerr=%b lost=%b, expected p=%0d per=%0d rerr=%b lost=%b",
                     i, obs_q[i].pulse, obs_q[i].period, obs_q[i].rerr, obs_q[i].lost,
                     exp_q[i].pulse, exp_q[i].period, exp_q[i].rerr, exp_q[i].lost);
         end
      end
   endtask

   task automatic test_range();
      int unsigned his[7] = '{120, 780, 150, 750, 147, 753, 450};
      apply_reset();
      foreach (his[i]) drive_pulse(his[i], 1200);
      final_rise();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL range_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL range_strobe%0d: got p=%0d per=%0d rerr=%b lost=%b, expected p=%0d per=%0d rerr=%b lost=%b",
                     i, obs_q[i].pulse, obs_q[i].period, obs_q[i].rerr, obs_q[i].lost,
                     exp_q[i].pulse, exp_q[i].period, exp_q[i].rerr, exp_q[i].lost);
         end
      end
   endtask

   task automatic test_timeout();
      int unsigned rise_cyc;
      apply_reset();
      drive_pulse(450, 1500);
      drive_pulse(450, 1500);
      @(negedge clk);
      model_rise();
      pend_valid = 1'b0;
      rise_cyc   = cyc;
      pwm_in     = 1'b1;
      repeat (450) @(negedge clk);
      pwm_in = 1'b0;
      while (cyc < rise_cyc + T_CYC + 2) @(negedge clk);
      checks++;
      if (signal_lost !== 1'b0) begin
         errors++;
         $display("FAIL timeout_early: lost=%b one cycle before timeout, expected 0", signal_lost);
      end
      @(negedge clk);
      checks++;
      if (signal_lost !== 1'b1) begin
         errors++;
         $display("FAIL timeout_edge: lost=%b at timeout, expected 1", signal_lost);
      end
      checks++;
      if (obs_q.size() != 2 || pulse_us !== CNT_W'(150) || period_us !== CNT_W'(500)) begin
         errors++;
         $display("FAIL timeout_hold: strobes=%0d p=%0d per=%0d, expected 2 150 500",
                  obs_q.size(), pulse_us, period_us);
      end
      drive_pulse(300, 1500);
      checks++;
      if (obs_q.size() != 2 || signal_lost !== 1'b1) begin
         errors++;
         $display("FAIL resume_first: strobes=%0d lost=%b, expected 2 1", obs_q.size(), signal_lost);
      end
      drive_pulse(600, 1800);
      final_rise();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL resume_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL resume_strobe%0d: got p=%0d per=%0d rerr=%b lost=%b, expected p=%0d per=%0d rerr=%b lost=%b",
                     i, obs_q[i].pulse, obs_q[i].period, obs_q[i].rerr, obs_q[i].lost,
                     exp_q[i].pulse, exp_q[i].period, exp_q[i].rerr, exp_q[i].lost);
         end
      end
   endtask

   task automatic test_floor();
      apply_reset();
      drive_pulse(451, 1501);
      drive_pulse(449, 1499);
      drive_pulse(452, 1502);
      final_rise();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL floor_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL floor_strobe%0d: got p=%0d per=%0d, expected p=%0d per=%0d",
                     i, obs_q[i].pulse, obs_q[i].period, exp_q[i].pulse, exp_q[i].period);
         end
      end
   endtask

   task automatic test_mid_reset();
      apply_reset();
      drive_pulse(450, 1500);
      @(negedge clk);
      pwm_in = 1'b1;
      repeat (100) @(negedge clk);
      checks++;
      if (pulse_us !== CNT_W'(150) || signal_lost !== 1'b0) begin
         errors++;
         $display("FAIL midrst_pre: p=%0d lost=%b, expected 150 0", pulse_us, signal_lost);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (pulse_us !== '0 || period_us !== '0 || meas_valid !== 1'b0 ||
          range_err !== 1'b0 || signal_lost !== 1'b1) begin
         errors++;
         $display("FAIL midrst_async: p=%0d per=%0d v=%b rerr=%b lost=%b, expected 0 0 0 0 1",
                  pulse_us, period_us, meas_valid, range_err, signal_lost);
      end
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      obs_q.delete();
      exp_q.delete();
      pend_valid = 1'b0;
      drive_pulse(420, 1400);
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL midrst_first: got %0d strobes after first rise, expected 0", obs_q.size());
      end
      drive_pulse(600, 1600);
      final_rise();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL midrst_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL midrst_strobe%0d: got p=%0d per=%0d, expected p=%0d per=%0d",
                     i, obs_q[i].pulse, obs_q[i].period, exp_q[i].pulse, exp_q[i].period);
         end
      end
   endtask

   task automatic test_stuck_high();
      int unsigned rise_cyc;
      apply_reset();
      @(negedge clk);
      rise_cyc = cyc;
      pwm_in   = 1'b1;
      while (cyc < rise_cyc + T_CYC + 10) @(negedge clk);
      checks++;
      if (obs_q.size() != 0 || signal_lost !== 1'b1) begin
         errors++;
         $display("FAIL stuck_wait: strobes=%0d lost=%b, expected 0 1", obs_q.size(), signal_lost);
      end
      // A fall after the timeout must be ignored, so the next rise only starts
      pwm_in = 1'b0;
      repeat (30) @(negedge clk);
      drive_pulse(300, 1500);
      checks++;
      if (obs_q.size() != 0) begin
         errors++;
         $display("FAIL stuck_restart: got %0d strobes after first rise, expected 0", obs_q.size());
      end
      final_rise();
      checks++;
      if (obs_q.size() != 1 || exp_q.size() != 1) begin
         errors++;
         $display("FAIL stuck_count: got %0d strobes, expected 1", obs_q.size());
      end else if (obs_q[0] !== exp_q[0]) begin
         errors++;
         $display("FAIL stuck_strobe: got p=%0d per=%0d, expected p=%0d per=%0d",
                  obs_q[0].pulse, obs_q[0].period, exp_q[0].pulse, exp_q[0].period);
      end
   endtask

   task automatic test_random();
      int unsigned hi;
      int unsigned per;
      apply_reset();
      for (int n = 0; n < 8; n++) begin
         hi  = $urandom_range(900, 120);
         per = hi + $urandom_range(1500, 60);
         drive_pulse(hi, per);
      end
      final_rise();
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL random_count: got %0d strobes, expected %0d", obs_q.size(), exp_q.size());
      end
      foreach (exp_q[i]) if (i < obs_q.size()) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++;
            $display("FAIL random_strobe%0d: got p=%0d per=%0d rerr=%b lost=%b, expected p=%0d per=%0d rerr=%b lost=%b",
                     i, obs_q[i].pulse, obs_q[i].period, obs_q[i].rerr, obs_q[i].lost,
                     exp_q[i].pulse, exp_q[i].period, exp_q[i].rerr, exp_q[i].lost);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_range();
      test_timeout();
      test_floor();
      test_mid_reset();
      test_stuck_high();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
